// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-bus signal bundle for mem_access_ctrl.
// slave = the sequencer; master = control unit plus memory.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    // Handshake: REQ is sampled only while BUSY=0; the request fields need only be
    // valid on that accepting edge. DONE is a one-cycle pulse, and RDATA and EA are
    // valid from the DONE cycle until the next transaction updates them.
    logic              REQ;
    logic              REQ_WE;
    logic              REQ_IND;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [DATA_W-1:0] REQ_WDATA;
    logic              BUSY;
    logic              DONE;
    logic [DATA_W-1:0] RDATA;
    logic [ADDR_W-1:0] EA;
    logic [15:0]       ACC_CNT;
    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_DIN;
    logic [DATA_W-1:0] MEM_DOUT;
    logic [1:0]        dbg_state;

    modport slave (
        input  REQ, REQ_WE, REQ_IND, REQ_ADDR, REQ_WDATA, MEM_DOUT,
        output BUSY, DONE, RDATA, EA, ACC_CNT,
        output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_DIN, dbg_state
    );

    modport master (
        output REQ, REQ_WE, REQ_IND, REQ_ADDR, REQ_WDATA, MEM_DOUT,
        input  BUSY, DONE, RDATA, EA, ACC_CNT,
        input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_DIN, dbg_state
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory bus sequencer for the Mano machine: one read or write at a time,
// with optional single-level indirection. All outputs are registered.
module mem_access_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input logic              CLK,
    input logic              RST,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INDIR  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    logic              busy;
    logic              done;
    logic              mem_read;
    logic              mem_write;
    logic              we_q;
    logic [ADDR_W-1:0] ea;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] rdata;
    logic [15:0]       acc_cnt;

    // mem_addr doubles as the indirection pointer while in INDIR, and
    // mem_din doubles as the latched write data for the whole transaction.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            we_q      <= 1'b0;
            ea        <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            rdata     <= '0;
            acc_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.REQ) begin
                        we_q     <= bus.REQ_WE;
                        mem_din  <= bus.REQ_WDATA;
                        mem_addr <= bus.REQ_ADDR;
                        busy     <= 1'b1;
                        if (bus.REQ_IND) begin
                            mem_read <= 1'b1;
                            state    <= INDIR;
                        end else begin
                            ea        <= bus.REQ_ADDR;
                            mem_read  <= ~bus.REQ_WE;
                            mem_write <= bus.REQ_WE;
                            state     <= ACCESS;
                        end
                    end
                end
                INDIR: begin
                    ea        <= bus.MEM_DOUT[ADDR_W-1:0];
                    mem_addr  <= bus.MEM_DOUT[ADDR_W-1:0];
                    mem_read  <= ~we_q;
                    mem_write <= we_q;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata <= bus.MEM_DOUT;
                    end
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    done      <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    acc_cnt <= acc_cnt + 16'd1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.BUSY      = busy;
    assign bus.DONE      = done;
    assign bus.RDATA     = rdata;
    assign bus.EA        = ea;
    assign bus.ACC_CNT   = acc_cnt;
    assign bus.MEM_READ  = mem_read;
    assign bus.MEM_WRITE = mem_write;
    assign bus.MEM_ADDR  = mem_addr;
    assign bus.MEM_DIN   = mem_din;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: behavioural 4096x16 memory,
// per-scenario tasks, and a DONE-driven scoreboard of expected RDATA/EA.
module tb_mem_access_ctrl;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam logic [1:0] S_INDIR = 2'd1;

    logic CLK = 1'b0;
    logic RST;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Memory model: commits on the rising edge, read data only while MEM_READ=1.
    logic [DATA_W-1:0] mem [0:4095];
    logic              poke_en;
    logic [ADDR_W-1:0] poke_addr;
    logic [DATA_W-1:0] poke_data;

    always @(posedge CLK) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (bus.MEM_WRITE) mem[bus.MEM_ADDR] <= bus.MEM_DIN;
    end

    assign bus.MEM_DOUT = bus.MEM_READ ? mem[bus.MEM_ADDR] : 16'hDEAD;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_ea_q[$];
    logic [DATA_W-1:0] last_rdata;
    logic [DATA_W-1:0] sb_rdata;
    logic [ADDR_W-1:0] sb_ea;

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge CLK);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(negedge CLK);
        poke_en   = 1'b0;
    endtask

    // Drives one request valid only on the accepting edge; returns 1ns after it.
    task automatic issue(input logic we, input logic ind, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        @(negedge CLK);
        bus.REQ       = 1'b1;
        bus.REQ_WE    = we;
        bus.REQ_IND   = ind;
        bus.REQ_ADDR  = a;
        bus.REQ_WDATA = d;
        @(posedge CLK);
        #1;
        bus.REQ       = 1'b0;
        bus.REQ_WE    = 1'($urandom_range(0, 1));
        bus.REQ_IND   = 1'($urandom_range(0, 1));
        bus.REQ_ADDR  = 12'($urandom_range(0, 4095));
        bus.REQ_WDATA = 16'($urandom_range(0, 65535));
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] r, input logic [ADDR_W-1:0] e);
        exp_q.push_back(r);
        exp_ea_q.push_back(e);
        last_rdata = r;
    endtask

    task automatic test_reset;
        @(negedge CLK);
        checks++;
        if ({bus.BUSY, bus.DONE, bus.MEM_READ, bus.MEM_WRITE} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 0000",
                     {bus.BUSY, bus.DONE, bus.MEM_READ, bus.MEM_WRITE});
        end
        checks++;
        if ({bus.RDATA, bus.EA, bus.ACC_CNT, bus.MEM_ADDR, bus.MEM_DIN} !== '0) begin
            errors++;
            $display("FAIL reset_regs: rdata=%h ea=%h cnt=%h addr=%h din=%h want all 0",
                     bus.RDATA, bus.EA, bus.ACC_CNT, bus.MEM_ADDR, bus.MEM_DIN);
        end
        RST = 1'b0;
    endtask

    task automatic test_direct_write_read;
        poke(12'h100, 16'h0000);
        push_exp(last_rdata, 12'h100);
        issue(1'b1, 1'b0, 12'h100, 16'hBEEF);
        @(negedge CLK);
        checks++;
        if ({bus.MEM_WRITE, bus.MEM_READ, bus.MEM_ADDR, bus.MEM_DIN} !== {2'b10, 12'h100, 16'hBEEF}) begin
            errors++;
            $display("FAIL wr_access: we=%b re=%b addr=%h din=%h want we=1 re=0 addr=100 din=beef",
                     bus.MEM_WRITE, bus.MEM_READ, bus.MEM_ADDR, bus.MEM_DIN);
        end
        @(negedge CLK);
        checks++;
        if ({bus.DONE, bus.MEM_WRITE} !== 2'b10) begin
            errors++;
            $display("FAIL wr_resp: done=%b we=%b want done=1 we=0", bus.DONE, bus.MEM_WRITE);
        end
        checks++;
        if (mem[12'h100] !== 16'hBEEF) begin
            errors++;
            $display("FAIL wr_mem: mem[100]=%h want beef", mem[12'h100]);
        end
        @(negedge CLK);
        checks++;
        if ({bus.BUSY, bus.DONE} !== 2'b00) begin
            errors++;
            $display("FAIL wr_idle: busy=%b done=%b want 0 0", bus.BUSY, bus.DONE);
        end
        push_exp(16'hBEEF, 12'h100);
        issue(1'b0, 1'b0, 12'h100, 16'h0000);
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.ACC_CNT !== 16'd2) begin
            errors++;
            $display("FAIL rd_count: got %0d want 2", bus.ACC_CNT);
        end
    endtask

    task automatic test_indirect_read;
        poke(12'h020, 16'hF345);
        poke(12'h345, 16'h1234);
        push_exp(16'h1234, 12'h345);
        issue(1'b0, 1'b1, 12'h020, 16'h0000);
        @(negedge CLK);
        checks++;
        if ({bus.MEM_READ, bus.MEM_ADDR, bus.dbg_state} !== {1'b1, 12'h020, S_INDIR}) begin
            errors++;
            $display("FAIL ind_ptr: re=%b addr=%h state=%0d want re=1 addr=020 state=1",
                     bus.MEM_READ, bus.MEM_ADDR, bus.dbg_state);
        end
        @(negedge CLK);
        checks++;
        if ({bus.MEM_READ, bus.MEM_ADDR, bus.DONE} !== {1'b1, 12'h345, 1'b0}) begin
            errors++;
            $display("FAIL ind_access: re=%b addr=%h done=%b want re=1 addr=345 done=0",
                     bus.MEM_READ, bus.MEM_ADDR, bus.DONE);
        end
        @(negedge CLK);
        checks++;
        if (bus.DONE !== 1'b1) begin
            errors++;
            $display("FAIL ind_done_cycle3: done=%b want 1", bus.DONE);
        end
        @(negedge CLK);
    endtask

    task automatic test_indirect_write;
        poke(12'h021, 16'h0ABC);
        poke(12'hABC, 16'h0000);
        push_exp(last_rdata, 12'hABC);
        issue(1'b1, 1'b1, 12'h021, 16'h5A5A);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if ({bus.MEM_WRITE, bus.MEM_READ, bus.MEM_ADDR} !== {2'b10, 12'hABC}) begin
            errors++;
            $display("FAIL indw_access: we=%b re=%b addr=%h want we=1 re=0 addr=abc",
                     bus.MEM_WRITE, bus.MEM_READ, bus.MEM_ADDR);
        end
        repeat (2) @(negedge CLK);
        checks++;
        if ({mem[12'hABC], mem[12'h021]} !== {16'h5A5A, 16'h0ABC}) begin
            errors++;
            $display("FAIL indw_mem: mem[abc]=%h mem[021]=%h want 5a5a 0abc",
                     mem[12'hABC], mem[12'h021]);
        end
        last_rdata = 16'h5A5A;
    endtask

    task automatic test_back_to_back;
        logic [ADDR_W-1:0] addrs[3];
        logic [DATA_W-1:0] datas[3];
        int dones;
        addrs = '{12'h100, 12'h345, 12'hABC};
        datas = '{16'hBEEF, 16'h1234, 16'h5A5A};
        dones = 0;
        for (int i = 0; i < 3; i++) push_exp(datas[i], addrs[i]);
        @(negedge CLK);
        bus.REQ      = 1'b1;
        bus.REQ_WE   = 1'b0;
        bus.REQ_IND  = 1'b0;
        bus.REQ_ADDR = addrs[0];
        for (int k = 0; k < 9; k++) begin
            @(posedge CLK);
            #1;
            if (k == 0) bus.REQ_ADDR = addrs[1];
            if (k == 3) bus.REQ_ADDR = addrs[2];
            if (k == 6) bus.REQ = 1'b0;
            @(negedge CLK);
            if (bus.DONE === 1'b1) dones++;
            checks++;
            if ({bus.BUSY, bus.DONE} !== {((k + 1) % 3) != 0, ((k + 1) % 3) == 2}) begin
                errors++;
                $display("FAIL b2b_cycle%0d: busy=%b done=%b want busy=%b done=%b", k + 1,
                         bus.BUSY, bus.DONE, ((k + 1) % 3) != 0, ((k + 1) % 3) == 2);
            end
        end
        checks++;
        if (dones != 3) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d want 3", dones);
        end
    endtask

    task automatic test_reset_mid_write;
        int dones;
        dones = 0;
        poke(12'h050, 16'h0001);
        issue(1'b1, 1'b0, 12'h050, 16'h7777);
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        checks++;
        if ({bus.MEM_WRITE, bus.BUSY, bus.DONE} !== 3'b000) begin
            errors++;
            $display("FAIL rst_abort_strobes: we=%b busy=%b done=%b want 000",
                     bus.MEM_WRITE, bus.BUSY, bus.DONE);
        end
        // Hold reset through the edge that would have committed the write.
        @(posedge CLK);
        #1;
        if (bus.DONE === 1'b1) dones++;
        // A request held high across reset release is accepted on the first free edge.
        bus.REQ      = 1'b1;
        bus.REQ_WE   = 1'b0;
        bus.REQ_IND  = 1'b0;
        bus.REQ_ADDR = 12'h345;
        @(negedge CLK);
        if (bus.DONE === 1'b1) dones++;
        checks++;
        if (mem[12'h050] !== 16'h0001) begin
            errors++;
            $display("FAIL rst_abort_mem: mem[050]=%h want 0001", mem[12'h050]);
        end
        checks++;
        if ({bus.RDATA, bus.EA, bus.ACC_CNT, bus.MEM_ADDR, bus.MEM_DIN} !== '0) begin
            errors++;
            $display("FAIL rst_abort_regs: rdata=%h ea=%h cnt=%h addr=%h din=%h want all 0",
                     bus.RDATA, bus.EA, bus.ACC_CNT, bus.MEM_ADDR, bus.MEM_DIN);
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL rst_abort_done: saw %0d DONE pulses want 0", dones);
        end
        push_exp(16'h1234, 12'h345);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        bus.REQ = 1'b0;
        @(negedge CLK);
        checks++;
        if ({bus.BUSY, bus.MEM_READ, bus.MEM_ADDR} !== {2'b11, 12'h345}) begin
            errors++;
            $display("FAIL rst_release_accept: busy=%b re=%b addr=%h want 1 1 345",
                     bus.BUSY, bus.MEM_READ, bus.MEM_ADDR);
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (bus.ACC_CNT !== 16'd1) begin
            errors++;
            $display("FAIL rst_release_count: got %0d want 1", bus.ACC_CNT);
        end
    endtask

    task automatic test_counter_wrap;
        @(negedge CLK);
        force dut.acc_cnt = 16'hFFFF;
        #1;
        release dut.acc_cnt;
        push_exp(16'hBEEF, 12'h100);
        issue(1'b0, 1'b0, 12'h100, 16'h0000);
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.ACC_CNT !== 16'h0000) begin
            errors++;
            $display("FAIL cnt_wrap: got %h want 0000", bus.ACC_CNT);
        end
    endtask

    initial begin
        RST           = 1'b1;
        poke_en       = 1'b0;
        poke_addr     = '0;
        poke_data     = '0;
        bus.REQ       = 1'b0;
        bus.REQ_WE    = 1'b0;
        bus.REQ_IND   = 1'b0;
        bus.REQ_ADDR  = '0;
        bus.REQ_WDATA = '0;
        last_rdata    = '0;

        fork
            forever begin
                @(negedge CLK);
                if (bus.DONE === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected_done: rdata=%h ea=%h with nothing expected",
                                 bus.RDATA, bus.EA);
                    end else begin
                        sb_rdata = exp_q.pop_front();
                        sb_ea    = exp_ea_q.pop_front();
                        if ({bus.RDATA, bus.EA} !== {sb_rdata, sb_ea}) begin
                            errors++;
                            $display("FAIL sb_resp: rdata=%h ea=%h want rdata=%h ea=%h",
                                     bus.RDATA, bus.EA, sb_rdata, sb_ea);
                        end
                    end
                end
            end
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        test_reset();
        test_direct_write_read();
        test_indirect_read();
        test_indirect_write();
        test_back_to_back();
        test_reset_mid_write();
        test_counter_wrap();

        repeat (2) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d responses never arrived, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Bus-master sequencer that drives the single-port 4096x16 memory on behalf of the Mano machine control unit. It accepts one read or write request at a time, optionally resolves one level of indirection (memory word holds the effective address), and issues the READ/WRITE/ADDRESS/DATA_IN strobes the memory expects. Read data and the resolved effective address are returned with a one-cycle DONE pulse. It sits between the control unit (AR/DR transfers) and the memory.

## Interface
- ADDR_W, 12, address width; must be <= DATA_W
- DATA_W, 16, word width
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  asynchronous, active-high reset
- REQ  in  1  request strobe; sampled only in IDLE
- REQ_WE  in  1  1 = write, 0 = read
- REQ_IND  in  1  1 = indirect: effective address = MEM[REQ_ADDR][ADDR_W-1:0]
- REQ_ADDR  in  ADDR_W  request address
- REQ_WDATA  in  DATA_W  write data
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse
- RDATA  out  DATA_W  last read word; held until next read completes
- EA  out  ADDR_W  effective address of current/last transaction
- ACC_CNT  out  16  completed-transaction count, wraps FFFF->0000
- MEM_READ  out  1  memory read enable
- MEM_WRITE  out  1  memory write enable (memory writes on the rising edge)
- MEM_ADDR  out  ADDR_W  memory address
- MEM_DIN  out  DATA_W  memory write data
- MEM_DOUT  in  DATA_W  memory read data (combinational while MEM_READ=1; not valid otherwise)

## Operation
- States: IDLE, INDIR, ACCESS, RESP.
- IDLE: MEM_READ=MEM_WRITE=0. On edge with REQ=1: latch REQ_WE, REQ_WDATA; if REQ_IND -> latch REQ_ADDR into pointer reg, go INDIR; else EA<=REQ_ADDR, go ACCESS. REQ=0 -> stay.
- INDIR: MEM_READ=1, MEM_ADDR=pointer. At edge EA<=MEM_DOUT[ADDR_W-1:0] (upper bits discarded); go ACCESS.
- ACCESS: MEM_ADDR=EA. Write: MEM_WRITE=1, MEM_DIN=latched wdata; memory commits at this edge. Read: MEM_READ=1; at edge RDATA<=MEM_DOUT. Go RESP.
- RESP: DONE=1, ACC_CNT<=ACC_CNT+1 at edge; go IDLE. REQ in RESP ignored (not queued).
- MEM_READ and MEM_WRITE never both 1. MEM_DOUT sampled only in cycles with MEM_READ=1.
- Outside INDIR/ACCESS: MEM_ADDR=EA, MEM_DIN=latched wdata (held, no strobes).
- Request inputs need only be valid on the accepting edge.
- Write leaves RDATA unchanged.

## Timing
- Accept edge = edge 0. Direct: ACCESS cycle 1, DONE high cycle 2, IDLE cycle 3; next request accepted earliest at edge 3.
- Indirect: INDIR cycle 1, ACCESS cycle 2, DONE cycle 3, IDLE cycle 4.
- RDATA/EA valid from the cycle DONE rises; stable until next transaction updates them.
- Reset (async, any state): state IDLE; BUSY, DONE, MEM_READ, MEM_WRITE = 0 immediately; RDATA, EA, ACC_CNT, MEM_ADDR, MEM_DIN, latched fields = 0. Reset asserted during ACCESS before the edge aborts the write (no memory update); no DONE is produced for an aborted transaction.
- REQ high on the edge RST deasserts-to-first-edge: first edge with RST=0 and REQ=1 accepts.

## Test plan
- Direct write then read: preload mem[0x100]=0; write 0xBEEF to 0x100 -> MEM_WRITE=1 one cycle with MEM_ADDR=0x100, DONE at cycle 2; read 0x100 -> RDATA=0xBEEF, EA=0x100, ACC_CNT=2.
- Indirect read: mem[0x020]=0xF345, mem[0x345]=0x1234; read IND 0x020 -> INDIR cycle MEM_ADDR=0x020, ACCESS MEM_ADDR=0x345, RDATA=0x1234, EA=0x345, DONE at cycle 3.
- Indirect write: mem[0x021]=0x0ABC; write IND 0x021 data 0x5A5A -> mem[0xABC]=0x5A5A, mem[0x021] unchanged, RDATA unchanged.
- Back-to-back: REQ held high continuously for three direct reads -> accepts at edges 0,3,6; exactly three DONE pulses; BUSY low only on cycles 3 and 6 boundaries (IDLE cycles).
- Reset mid-write: assert RST during ACCESS of write 0x7777 to 0x050 (prior 0x0001) -> MEM_WRITE drops immediately, mem[0x050]=0x0001, no DONE, all outputs 0, ACC_CNT=0.
- Counter wrap: force 65536 completions (or 65535 then one) -> ACC_CNT reads 0x0000 after wrap.
